// File: rtl/delay_req_arbiter_if.sv
// delay_req_arbiter_if: requester-side and delay_master-side signals of the
// delay request arbiter. slave = arbiter view, master = requesters + delay_master.
interface delay_req_arbiter_if #(
  parameter int data_width = 16,
  parameter int n_req      = 4
);
  logic [n_req-1:0]                 req_read;
  logic [n_req-1:0]                 req_write;
  logic [n_req-1:0][data_width-1:0] req_handle;
  logic [n_req-1:0][data_width-1:0] req_write_data;
  logic [n_req-1:0][data_width-1:0] req_write_inc;
  logic [n_req-1:0]                 rsp_read_valid;
  logic [n_req-1:0]                 rsp_write_ack;
  logic [data_width-1:0]            rsp_data;
  logic                             dm_read_req;
  logic                             dm_write_req;
  logic [data_width-1:0]            dm_handle;
  logic [data_width-1:0]            dm_write_data;
  logic [data_width-1:0]            dm_write_inc;
  logic [data_width-1:0]            dm_read_data;
  logic                             dm_read_valid;
  logic                             dm_write_ack;
  logic                             busy;
  logic                             timeout_err;

  modport slave (
    input  req_read, req_write, req_handle, req_write_data, req_write_inc,
    output rsp_read_valid, rsp_write_ack, rsp_data,
    output dm_read_req, dm_write_req, dm_handle, dm_write_data, dm_write_inc,
    input  dm_read_data, dm_read_valid, dm_write_ack,
    output busy, timeout_err
  );

  modport master (
    output req_read, req_write, req_handle, req_write_data, req_write_inc,
    input  rsp_read_valid, rsp_write_ack, rsp_data,
    input  dm_read_req, dm_write_req, dm_handle, dm_write_data, dm_write_inc,
    output dm_read_data, dm_read_valid, dm_write_ack,
    input  busy, timeout_err
  );
endinterface

// File: rtl/delay_req_arbiter.sv
// delay_req_arbiter: round-robin sharing of one delay_master port among n_req
// requesters. One transaction in flight: IDLE -> ISSUE -> WAIT -> RELEASE.
// Optional WAIT timeout enabled by defining DELAY_ARB_TIMEOUT_EN.
module delay_req_arbiter #(
  parameter int data_width     = 16,
  parameter int n_req          = 4,
  parameter int timeout_cycles = 1023
) (
  input logic               clk,
  input logic               reset,
  delay_req_arbiter_if.slave bus
);
  localparam int PW = (n_req > 1) ? $clog2(n_req) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         rr_ptr, owner, grant_idx;
  logic                  grant_vld;
  logic                  op_read;
  logic [data_width-1:0] handle_q, wdata_q, winc_q, rsp_data_q;
  logic [n_req-1:0]      rsp_rv_q, rsp_wa_q, pend;
  logic                  done_ok, abort;

  assign pend    = bus.req_read | bus.req_write;
  // only the completion matching the latched op ends WAIT
  assign done_ok = (state == WAIT) && (op_read ? bus.dm_read_valid : bus.dm_write_ack);

  // first pending requester at or after rr_ptr (descending scan so the nearest wins)
  always_comb begin
    int j;
    grant_vld = 1'b0;
    grant_idx = '0;
    j         = 0;
    for (int k = n_req - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= n_req) j = j - n_req;
      if (pend[j]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(j);
      end
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (done_ok || abort) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state, latched request, response pulses and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      op_read    <= 1'b0;
      handle_q   <= '0;
      wdata_q    <= '0;
      winc_q     <= '0;
      rsp_data_q <= '0;
      rsp_rv_q   <= '0;
      rsp_wa_q   <= '0;
    end else begin
      state    <= state_nxt;
      rsp_rv_q <= '0;
      rsp_wa_q <= '0;
      if (state == IDLE && grant_vld) begin
        owner    <= grant_idx;
        op_read  <= bus.req_read[grant_idx];
        handle_q <= bus.req_handle[grant_idx];
        wdata_q  <= bus.req_write_data[grant_idx];
        winc_q   <= bus.req_write_inc[grant_idx];
      end
      if (done_ok || abort) begin
        if (op_read) rsp_rv_q[owner] <= 1'b1;
        else         rsp_wa_q[owner] <= 1'b1;
        if (abort)        rsp_data_q <= '0;
        else if (op_read) rsp_data_q <= bus.dm_read_data;
        rr_ptr <= (owner == PW'(n_req - 1)) ? '0 : owner + PW'(1);
      end
    end
  end

`ifdef DELAY_ARB_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles + 1);
  logic [TW-1:0] to_cnt;
  logic          timeout_q;

  // abort on the timeout_cycles-th WAIT cycle without a matching completion
  assign abort = (state == WAIT) && !done_ok && (to_cnt == TW'(timeout_cycles - 1));

  // WAIT-cycle counter (cleared while in ISSUE) and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ISSUE)     to_cnt <= '0;
      else if (state == WAIT) to_cnt <= to_cnt + TW'(1);
      if (abort) timeout_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  assign abort           = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.dm_read_req    = (state == ISSUE) && op_read;
  assign bus.dm_write_req   = (state == ISSUE) && !op_read;
  assign bus.dm_handle      = handle_q;
  assign bus.dm_write_data  = wdata_q;
  assign bus.dm_write_inc   = winc_q;
  assign bus.rsp_read_valid = rsp_rv_q;
  assign bus.rsp_write_ack  = rsp_wa_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.busy           = (state != IDLE);
endmodule

// File: tb/tb_delay_req_arbiter.sv
// tb_delay_req_arbiter: directed cases plus randomized traffic, all checked every
// cycle against a transaction-level model (grant cycle, issue = grant+1,
// response = accepting cycle+1, free after the response cycle).
module tb_delay_req_arbiter;
  localparam int DW = 16, N = 4, TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  delay_req_arbiter_if #(.data_width(DW), .n_req(N)) bus ();
  delay_req_arbiter #(.data_width(DW), .n_req(N), .timeout_cycles(TO)) dut (
    .clk(clk), .reset(rst), .bus(bus));

  int n_tests = 0, n_fail = 0, cyc = 0;

  // model state
  bit          m_act, m_rd, m_terr;
  int          m_g, m_rsp, m_own, m_ptr;
  logic [DW-1:0] m_lh, m_ld, m_li, m_rdata;
  bit          silent;
  logic [N-1:0] prev_rv, prev_wa;
  logic [DW-1:0] q_h[$];
  bit          q_rd[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_rd = 0; m_terr = 0; m_g = -10; m_rsp = -1; m_own = 0; m_ptr = 0;
    m_lh = '0; m_ld = '0; m_li = '0; m_rdata = '0;
  endtask

  task automatic model_check();
    logic [N-1:0] erv, ewa;
    erv = '0; ewa = '0;
    if (m_act && cyc == m_rsp) begin
      if (m_rd) erv[m_own] = 1'b1; else ewa[m_own] = 1'b1;
    end
    chk("busy",          32'(bus.busy),         32'(m_act));
    chk("dm_read_req",   32'(bus.dm_read_req),  32'(m_act && cyc == m_g + 1 && m_rd));
    chk("dm_write_req",  32'(bus.dm_write_req), 32'(m_act && cyc == m_g + 1 && !m_rd));
    chk("dm_handle",     32'(bus.dm_handle),     32'(m_lh));
    chk("dm_write_data", 32'(bus.dm_write_data), 32'(m_ld));
    chk("dm_write_inc",  32'(bus.dm_write_inc),  32'(m_li));
    chk("rsp_read_valid", 32'(bus.rsp_read_valid), 32'(erv));
    chk("rsp_write_ack",  32'(bus.rsp_write_ack),  32'(ewa));
    chk("rsp_data",      32'(bus.rsp_data),      32'(m_rdata));
    chk("timeout_err",   32'(bus.timeout_err),   32'(m_terr));
  endtask

  // advance the model over the inputs now applied for cycle cyc
  task automatic model_update();
    if (rst) model_reset();
    else if (!m_act) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!m_act && (bus.req_read[j] || bus.req_write[j])) begin
          m_act = 1; m_g = cyc; m_rsp = -1; m_own = j; m_rd = bus.req_read[j];
          m_lh = bus.req_handle[j]; m_ld = bus.req_write_data[j]; m_li = bus.req_write_inc[j];
        end
      end
    end else if (m_rsp < 0) begin
      if (cyc >= m_g + 2) begin
        if (m_rd ? bus.dm_read_valid : bus.dm_write_ack) begin
          m_rsp = cyc + 1;
          if (m_rd) m_rdata = bus.dm_read_data;
        end
`ifdef DELAY_ARB_TIMEOUT_EN
        else if (cyc - (m_g + 1) == TO) begin
          m_rsp = cyc + 1; m_rdata = '0; m_terr = 1;
        end
`endif
      end
    end else if (cyc == m_rsp) begin
      m_act = 0; m_ptr = (m_own + 1) % N;
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    if (bus.dm_read_req || bus.dm_write_req) begin
      q_h.push_back(bus.dm_handle);
      q_rd.push_back(bus.dm_read_req);
    end
  endtask

  task automatic apply();
    model_update();
  endtask

  // self-driving requesters and delay_master; opsel 0 read, 1 write, 2 both, 3 random
  task automatic run(input int ncyc, input int p_new, input int p_dm, input int opsel, input int p_rst);
    for (int c = 0; c < ncyc; c++) begin
      step();
      if (m_act && cyc == m_g + 1) begin
`ifdef DELAY_ARB_TIMEOUT_EN
        silent = (p_rst > 0) && ($urandom_range(0, 5) == 0);
`else
        silent = 0;
`endif
      end
      rst = (p_rst > 0) && ($urandom_range(0, p_rst - 1) == 0);
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          bus.req_read[i] = 0; bus.req_write[i] = 0;
        end else if (prev_rv[i] || prev_wa[i]) begin
          if (prev_rv[i]) bus.req_read[i] = 0;
          if (prev_wa[i]) bus.req_write[i] = 0;
        end else if (!bus.req_read[i] && !bus.req_write[i] && $urandom_range(0, 99) < p_new) begin
          int op;
          op = (opsel == 3) ? int'($urandom_range(0, 2)) : opsel;
          bus.req_read[i]       = (op != 1);
          bus.req_write[i]      = (op != 0);
          bus.req_handle[i]     = (opsel == 3) ? DW'($urandom) : DW'(16 + i);
          bus.req_write_data[i] = DW'($urandom);
          bus.req_write_inc[i]  = DW'($urandom);
        end
      end
      prev_rv = bus.rsp_read_valid;
      prev_wa = bus.rsp_write_ack;
      bus.dm_read_valid = ($urandom_range(0, 99) < p_dm);
      bus.dm_write_ack  = ($urandom_range(0, 99) < p_dm);
      if (silent && m_act) begin
        bus.dm_read_valid = 0; bus.dm_write_ack = 0;
      end
      bus.dm_read_data = DW'($urandom);
      apply();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    bus.req_read = '0; bus.req_write = '0;
    bus.req_handle = '0; bus.req_write_data = '0; bus.req_write_inc = '0;
    bus.dm_read_data = '0; bus.dm_read_valid = 0; bus.dm_write_ack = 0;
    model_reset(); silent = 0; prev_rv = '0; prev_wa = '0;

    // reset state
    step();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_dm", 32'({bus.dm_read_req, bus.dm_write_req, bus.dm_handle}), 0);
    chk("rst_rsp", 32'({bus.rsp_read_valid, bus.rsp_write_ack}), 0);
    apply();

    // single read, port 2
    step(); rst = 0; bus.req_read[2] = 1; bus.req_handle[2] = 16'd3; apply();
    step(); chk("t1_rd_pulse", 32'(bus.dm_read_req), 1); chk("t1_handle", 32'(bus.dm_handle), 3); apply();
    step(); chk("t1_pulse_once", 32'(bus.dm_read_req), 0);
    bus.dm_read_valid = 1; bus.dm_read_data = 16'h1234; apply();
    step(); chk("t1_rsp", 32'(bus.rsp_read_valid), 32'h4); chk("t1_rdata", 32'(bus.rsp_data), 32'h1234);
    bus.dm_read_valid = 0; apply();
    step(); chk("t1_rsp_once", 32'(bus.rsp_read_valid), 0); chk("t1_idle", 32'(bus.busy), 0);
    bus.req_read[2] = 0; apply();

    // read and write on port 1: read first, write on a later grant
    step(); bus.req_read[1] = 1; bus.req_write[1] = 1; bus.req_handle[1] = 16'h0007;
    bus.req_write_data[1] = 16'h00aa; bus.req_write_inc[1] = 16'h0002; apply();
    q_h.delete(); q_rd.delete(); prev_rv = '0; prev_wa = '0;
    run(16, 0, 100, 0, 0);
    chk("t2_n_issue", 32'(q_h.size()), 2);
    chk("t2_first_read", 32'(q_rd[0]), 1);
    chk("t2_second_write", 32'(q_rd[1]), 0);
    chk("t2_handle", 32'(q_h[1]), 32'h7);

    // wrong completion ignored, simultaneous completions: only the matching one
    step(); bus.dm_read_valid = 0; bus.dm_write_ack = 0;
    bus.req_write[0] = 1; bus.req_handle[0] = 16'h21; bus.req_write_data[0] = 16'hd00d;
    bus.req_write_inc[0] = 16'h1; apply();
    step(); chk("t4_wr_pulse", 32'(bus.dm_write_req), 1); chk("t4_wdata", 32'(bus.dm_write_data), 32'hd00d); apply();
    step(); bus.dm_read_valid = 1; bus.dm_read_data = 16'hbeef; apply();
    step(); chk("t4_wrong_ignored", 32'({bus.busy, bus.rsp_read_valid, bus.rsp_write_ack}), 32'h100);
    bus.dm_write_ack = 1; apply();
    step(); chk("t4_ack", 32'(bus.rsp_write_ack), 32'h1); chk("t4_no_rv", 32'(bus.rsp_read_valid), 0);
    bus.dm_read_valid = 0; bus.dm_write_ack = 0; apply();
    step(); bus.req_write[0] = 0; apply();

    // reset in WAIT abandons the read and restarts the pointer at 0
    step(); bus.req_read[3] = 1; bus.req_handle[3] = 16'h33; apply();
    step(); apply();
    step(); rst = 1; apply();
    step(); chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_dm", 32'(|{bus.dm_read_req, bus.dm_write_req, bus.dm_handle, bus.dm_write_data, bus.dm_write_inc}), 0);
    chk("t5_no_rsp", 32'({bus.rsp_read_valid, bus.rsp_write_ack}), 0);
    rst = 0; bus.req_read[1] = 1; bus.req_handle[1] = 16'h11; apply();
    step(); chk("t5_ptr0_grant1", 32'(bus.dm_handle), 32'h11); apply();
    prev_rv = '0; prev_wa = '0;
    run(20, 0, 100, 3, 0);

`ifdef DELAY_ARB_TIMEOUT_EN
    // unanswered read aborts after TO WAIT cycles, next requester follows
    step(); bus.dm_read_valid = 0; bus.dm_write_ack = 0;
    bus.req_read[0] = 1; bus.req_handle[0] = 16'h40;
    bus.req_read[1] = 1; bus.req_handle[1] = 16'h41; apply();
    for (int k = 0; k < 9; k++) begin step(); apply(); end
    step(); chk("t6_rv", 32'(bus.rsp_read_valid), 32'h1); chk("t6_rdata0", 32'(bus.rsp_data), 0);
    chk("t6_terr", 32'(bus.timeout_err), 1); apply();
    step(); bus.req_read[0] = 0; apply();
    step(); chk("t6_next", 32'(bus.dm_handle), 32'h41); chk("t6_sticky", 32'(bus.timeout_err), 1);
    bus.dm_read_valid = 1; apply();
    step(); apply();
    step(); chk("t6_rv2", 32'(bus.rsp_read_valid), 32'h2); apply();
    step(); bus.req_read[1] = 0; bus.dm_read_valid = 0; chk("t6_sticky2", 32'(bus.timeout_err), 1);
    rst = 1; apply();
    step(); chk("t6_terr_clr", 32'(bus.timeout_err), 0); rst = 0; apply();
`else
    // without the timeout a silent delay_master keeps the arbiter in WAIT
    step(); bus.dm_read_valid = 0; bus.dm_write_ack = 0;
    bus.req_read[0] = 1; bus.req_handle[0] = 16'h40; apply();
    for (int k = 0; k < 40; k++) begin step(); apply(); end
    step(); chk("t6_still_busy", 32'(bus.busy), 1); chk("t6_no_rsp", 32'(bus.rsp_read_valid), 0);
    bus.dm_read_valid = 1; apply();
    step(); chk("t6_late_rsp", 32'(bus.rsp_read_valid), 32'h1); bus.dm_read_valid = 0; apply();
    step(); bus.req_read[0] = 0; apply();
`endif

    // round robin with all four writers continuously requesting
    step(); rst = 1; apply();
    step(); rst = 0;
    for (int i = 0; i < N; i++) begin
      bus.req_read[i] = 0; bus.req_write[i] = 1; bus.req_handle[i] = DW'(16 + i);
    end
    apply();
    q_h.delete(); q_rd.delete(); prev_rv = '0; prev_wa = '0;
    run(18, 100, 100, 1, 0);
    chk("t3_n_grants", 32'(q_h.size()), 5);
    chk("t3_g0", 32'(q_h[0]), 16);
    chk("t3_g1", 32'(q_h[1]), 17);
    chk("t3_g2", 32'(q_h[2]), 18);
    chk("t3_g3", 32'(q_h[3]), 19);
    chk("t3_g4", 32'(q_h[4]), 16);

    // randomized traffic with occasional resets
    run(3000, 25, 30, 3, 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/delay_req_arbiter.md
Name: delay_req_arbiter

Overview:
Round-robin arbiter that shares one delay_master read/write port among n_req requesters (DSP core, tap-tempo/modulation engines, debug probe). It latches one request at a time, issues it to delay_master as a single-cycle pulse, and waits for read_valid or write_ack. It then routes a one-cycle response pulse back to the owner. Sits between requesters and delay_master in dsp_pipeline.

Parameters:
data_width, 16, sample/handle/data width
n_req, 4, number of requesters (2..8)
timeout_cycles, 1023, WAIT cycles before abort (used only with DELAY_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
req_read  in  n_req  per-requester read request; level, held until response
req_write  in  n_req  per-requester write request; level, held until response
req_handle  in  n_req*data_width  buffer handle; slice i belongs to requester i
req_write_data  in  n_req*data_width  write sample per requester
req_write_inc  in  n_req*data_width  write-pointer increment per requester
rsp_read_valid  out  n_req  one-cycle read-completion pulse to owner
rsp_write_ack  out  n_req  one-cycle write-completion pulse to owner
rsp_data  out  data_width  read data; valid while rsp_read_valid is high
dm_read_req  out  1  read pulse to delay_master
dm_write_req  out  1  write pulse to delay_master
dm_handle  out  data_width  latched handle
dm_write_data  out  data_width  latched write data
dm_write_inc  out  data_width  latched increment
dm_read_data  in  data_width  delay_master read data
dm_read_valid  in  1  delay_master read done
dm_write_ack  in  1  delay_master write done
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky abort flag

Behaviour:
- Reset: state IDLE, rr_ptr=0, all outputs 0, latched fields 0, timeout_err=0. Reset mid-operation abandons the transaction; no response is pulsed.
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE:
  - A requester is pending if req_read[i] or req_write[i] is set.
  - Grant the first pending index scanning rr_ptr, rr_ptr+1, ... mod n_req.
  - Latch owner, op, handle, data and inc from the owner's slices. Go to ISSUE.
  - op=READ if req_read[owner], else WRITE. Read wins when both are set; the write is served on a later grant.
- ISSUE: dm_read_req or dm_write_req (per op) high for exactly this cycle. dm_handle, dm_write_data and dm_write_inc are driven from the latched fields and stay stable until IDLE. Go to WAIT.
- WAIT:
  - Accept only the completion matching op: dm_read_valid for READ, dm_write_ack for WRITE. The other signal is ignored, including when both arrive on the same cycle.
  - On acceptance, at the next edge: the owner's rsp bit goes high for one cycle; for READ, rsp_data <= dm_read_data. Set rr_ptr <= (owner+1) mod n_req. Go to RELEASE.
- RELEASE: one cycle; ignores all requests so the owner can drop its level request. Go to IDLE. rsp_data holds until the next read completion.
- dm_read_valid and dm_write_ack outside WAIT are ignored.
- Latency with a 1-cycle delay_master:
  - Request seen at edge k, dm pulse in cycle k, completion sampled at edge k+2, rsp pulse in cycle k+2.
  - Back-to-back grants are 4 cycles apart minimum.
- Fairness: a continuously requesting port waits at most n_req-1 transactions.
- Requester contract: hold the request and its data stable until the rsp pulse; deassert on the following cycle. Changing fields after the grant has no effect.

Optional Feature:
- Macro DELAY_ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. On reaching timeout_cycles with no matching completion:
  - set timeout_err (sticky until reset);
  - pulse the owner's expected rsp bit with rsp_data=0;
  - advance rr_ptr and go to RELEASE.
- Undefined: WAIT is unbounded, no counter is synthesised, timeout_err is tied 0.

Test Plan:
- Single read: n_req=4, req_read[2]=1, handle=3, dm_read_valid with 0x1234 one cycle after the pulse -> dm_read_req single pulse with dm_handle=3; rsp_read_valid=4'b0100 for one cycle; rsp_data=0x1234; busy low 2 cycles later.
- Round-robin: all four req_write held, dm_write_ack answers each -> grant order 0,1,2,3,0; exactly one dm_write_req per grant; no requester granted twice in a row while others pend.
- Read+write same port: req_read[1]=req_write[1]=1 -> read issued first, then write on the next grant of port 1; two separate rsp pulses.
- Wrong/simultaneous completion: WRITE in WAIT with dm_read_valid=1 alone -> ignored, stays WAIT; then dm_read_valid=dm_write_ack=1 -> write accepted, rsp_read_valid stays 0.
- Reset mid-WAIT: reset asserted in WAIT -> next cycle IDLE, no rsp pulse, rr_ptr=0, all dm_* outputs 0.
- Timeout (DELAY_ARB_TIMEOUT_EN, timeout_cycles=8): read with no completion -> after 8 WAIT cycles timeout_err=1, rsp_read_valid pulse with rsp_data=0, next requester granted; flag stays 1 until reset.
